// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer for step sequencing: per-channel prescaler
// and downcounter with one-shot / auto-reload modes, pause, abort and count readback.
module multi_delay_timer #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 500000,
  parameter int PRE_W    = 20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*CNT_W-1:0] delay,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       done_pulse,
  output logic [CHANNELS*CNT_W-1:0] remaining
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           state_r;
    logic [PRE_W-1:0] pre_r;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] reload_r;
    logic             per_r;
    logic             busy_r;
    logic             done_r;
    logic             pulse_r;
    logic [CNT_W-1:0] delay_s;

    assign delay_s = delay[gi*CNT_W +: CNT_W];

    // Channel FSM: reset > abort > start > count; all outputs come straight from these registers.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_r  <= IDLE;
        pre_r    <= {PRE_W{1'b0}};
        rem_r    <= {CNT_W{1'b0}};
        reload_r <= {CNT_W{1'b0}};
        per_r    <= 1'b0;
        busy_r   <= 1'b0;
        done_r   <= 1'b0;
        pulse_r  <= 1'b0;
      end else if (abort[gi]) begin
        state_r  <= IDLE;
        pre_r    <= {PRE_W{1'b0}};
        rem_r    <= {CNT_W{1'b0}};
        busy_r   <= 1'b0;
        done_r   <= 1'b0;
        pulse_r  <= 1'b0;
      end else if (start[gi]) begin
        pre_r    <= {PRE_W{1'b0}};
        rem_r    <= delay_s;
        reload_r <= delay_s;
        per_r    <= periodic[gi];
        if (delay_s != {CNT_W{1'b0}}) begin
          state_r <= RUN;
          busy_r  <= 1'b1;
          done_r  <= 1'b0;
          pulse_r <= 1'b0;
        end else begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          pulse_r <= 1'b1;
        end
      end else begin
        pulse_r <= 1'b0;
        case (state_r)
          IDLE: begin
            pre_r <= {PRE_W{1'b0}};
          end
          RUN: begin
            if (enable[gi]) begin
              if (pre_r >= PRE_MAX) begin
                pre_r <= {PRE_W{1'b0}};
                // A count of 0 while running is unreachable; treating it as expiry keeps it from wrapping.
                if (rem_r <= CNT_W'(1)) begin
                  pulse_r <= 1'b1;
                  done_r  <= 1'b1;
                  if (per_r) begin
                    rem_r <= reload_r;
                  end else begin
                    rem_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                  end
                end else begin
                  rem_r <= rem_r - CNT_W'(1);
                end
              end else begin
                pre_r <= pre_r + PRE_W'(1);
              end
            end else begin
              pre_r <= pre_r;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            pre_r   <= {PRE_W{1'b0}};
          end
        endcase
      end
    end

    assign busy[gi]                      = busy_r;
    assign done[gi]                      = done_r;
    assign done_pulse[gi]                = pulse_r;
    assign remaining[gi*CNT_W +: CNT_W]  = rem_r;
  end

endmodule
